md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
Multi-cycle multiply/divide controller that owns the HI/LO registers alongside the single-cycle ALU in the E stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per start pulse and counts out a fixed latency. It raises busy and stall_req so the hazard unit holds younger HI/LO-dependent instructions in D. It commits results to HI/LO at the end of the count, and honours a same-cycle cancel from the exception logic.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  E-stage instruction is an md op this cycle
md_op  input  3  operation code from md_pkg (valid when start=1)
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
cancel  input  1  exception/interrupt flush this cycle; suppresses a same-cycle start
busy  output  1  high while a mult/div is counting
stall_req  output  1  combinational: busy | (start & op is MULT/MULTU/DIV/DIVU)
hi  output  32  HI register (read by MFHI)
lo  output  32  LO register (read by MFLO)

Behaviour:
- Reset (sync, active-high): state=IDLE, busy=0, hi=0, lo=0, count=0, pending result=0.
- Reset mid-operation aborts the operation; hi/lo are cleared, not written.
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Codes 7 and NONE are no-ops.
- Accept condition: start & !cancel & state==IDLE.
- States:
  - IDLE: on accepted MULT/MULTU/DIV/DIVU at edge t, the pending {hi_n, lo_n} is computed from A/B and latched. count is loaded with MULT_CYCLES or DIV_CYCLES, and the state goes to BUSY.
  - IDLE: on accepted MTHI/MTLO, hi<=A or lo<=A at the same edge. No busy.
- BUSY:
  - busy=1 for exactly N cycles after edge t; count decrements each edge.
  - At the edge where count==1, hi<=hi_n, lo<=lo_n and the state returns to IDLE.
  - New values are visible in cycle t+N+1.
- start while BUSY: ignored, no state change. The hazard unit must never present this; the bench asserts on it.
- cancel:
  - Gates only the start cycle.
  - An op already in BUSY always completes.
  - cancel with MTHI/MTLO blocks the write.
- Arithmetic:
  - MULT is a signed 32x32->64 product; MULTU is unsigned. hi=product[63:32], lo=product[31:0].
  - DIV: lo is the signed quotient truncated toward zero, and hi is the remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (either div): hi=A, lo=32'hFFFFFFFF.
  - DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- hi/lo outputs are registers; no bypass of the pending result.
- stall_req is combinational and has no dependence on cancel.

Decomposition:
- md_pkg holds:
  - the 3-bit op-code constants (MD_NONE..MD_MTLO);
  - default cycle constants;
  - an is_md_busy_op(op) function shared with the hazard unit.
- Sub-module md_compute: purely combinational (A, B, md_op) -> {hi_n, lo_n}. It contains the signed/unsigned multiply, divide, and the div-by-zero and overflow rules.
- md_ctrl keeps only the FSM, the counter and the HI/LO registers.

Test Plan:
- MULT A=32'hFFFFFFFF, B=2, start at cycle 0 -> busy=1 cycles 1-5; hi=32'hFFFFFFFF, lo=32'hFFFFFFFE visible cycle 6.
- MULTU same operands -> hi=32'h00000001, lo=32'hFFFFFFFE after 5 busy cycles.
- DIV A=32'hFFFFFFF9 (-7), B=2 -> busy 10 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU A=7, B=0 -> hi=7, lo=32'hFFFFFFFF. Also DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- MULT with cancel=1 in its start cycle -> busy stays 0 and hi/lo unchanged. MTHI A=32'h12345678 with cancel=0 -> hi=32'h12345678 next cycle, busy=0.
- DIV started, reset=1 at busy cycle 4 -> next cycle busy=0, hi=lo=0. A start during BUSY -> ignored, original result commits on schedule.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default
// latencies, the FSM state type and the busy-op classifier that the
// hazard unit also uses.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // True for the ops that occupy the unit for a multi-cycle count.
    function automatic logic is_md_busy_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the divide ops (they use the longer latency).
    function automatic logic is_md_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath. Produces the {hi, lo} pair that
// the controller latches at the accept edge and commits at the end of the
// count. Divide-by-zero and the signed overflow case are resolved here so
// the result never depends on simulator/synthesis divide semantics.
module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] squot;
    logic signed [31:0] srem;
    logic        [31:0] uquot;
    logic        [31:0] urem;

    assign a_sx  = {{32{A[31]}}, A};
    assign b_sx  = {{32{B[31]}}, B};
    assign sprod = a_sx * b_sx;
    assign uprod = {32'd0, A} * {32'd0, B};

    assign a_s   = A;
    assign b_s   = B;
    assign squot = a_s / b_s;
    assign srem  = a_s % b_s;
    assign uquot = A / B;
    assign urem  = A % B;

    // Select the result for the current op; zero divisor and the
    // most-negative / -1 overflow take fixed answers.
    always_comb begin
        hi_n = 32'd0;
        lo_n = 32'd0;
        case (md_op)
            MD_MULT: begin
                hi_n = sprod[63:32];
                lo_n = sprod[31:0];
            end
            MD_MULTU: begin
                hi_n = uprod[63:32];
                lo_n = uprod[31:0];
            end
            MD_DIV: begin
                if (B == 32'd0) begin
                    hi_n = A;
                    lo_n = 32'hFFFF_FFFF;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    hi_n = 32'd0;
                    lo_n = 32'h8000_0000;
                end else begin
                    hi_n = srem;
                    lo_n = squot;
                end
            end
            MD_DIVU: begin
                if (B == 32'd0) begin
                    hi_n = A;
                    lo_n = 32'hFFFF_FFFF;
                end else begin
                    hi_n = urem;
                    lo_n = uquot;
                end
            end
            default: begin
                hi_n = 32'd0;
                lo_n = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: owns HI/LO, accepts one op per start pulse,
// counts out a fixed latency while busy, then commits the latched result.
// A same-cycle cancel suppresses the start; an op already counting always
// completes unless reset aborts it.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    md_state_t   state;
    logic [3:0]  count;
    logic [31:0] hi_pend;
    logic [31:0] lo_pend;
    logic [31:0] hi_n;
    logic [31:0] lo_n;
    logic        accept;

    md_compute u_compute (
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .hi_n  (hi_n),
        .lo_n  (lo_n)
    );

    assign accept = start & ~cancel & (state == ST_IDLE);

    // Hold younger HI/LO readers while counting or when a long op arrives;
    // cancel is deliberately not considered here.
    assign stall_req = busy | (start & is_md_busy_op(md_op));

    // FSM, latency counter, pending result and the architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            count   <= 4'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_md_busy_op(md_op)) begin
                            hi_pend <= hi_n;
                            lo_pend <= lo_n;
                            count   <= is_md_div_op(md_op) ? DIV_CNT : MULT_CNT;
                            busy    <= 1'b1;
                            state   <= ST_BUSY;
                        end else if (md_op == MD_MTHI) begin
                            hi <= A;
                        end else if (md_op == MD_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                ST_BUSY: begin
                    if (count == 4'd1) begin
                        hi    <= hi_pend;
                        lo    <= lo_pend;
                        count <= 4'd0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with a scoreboard of expected HI/LO results.
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    md_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .A         (a),
        .B         (b),
        .cancel    (cancel),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a long op, check busy for exactly n cycles, then pop and compare.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int n);
        exp_t        e;
        exp_t        got;
        logic [31:0] ph;
        logic [31:0] pl;
        e.hi = eh;
        e.lo = el;
        sb.push_back(e);
        ph = hi;
        pl = lo;
        start = 1'b1;
        md_op = op;
        a     = av;
        b     = bv;
        #1;
        chk({tag, " stall_req@start"}, 32'(stall_req), 32'd1);
        step();
        start = 1'b0;
        md_op = MD_NONE;
        for (int i = 1; i <= n; i++) begin
            chk($sformatf("%s busy@%0d", tag, i), 32'(busy), 32'd1);
            if (i == n) begin
                chk({tag, " hi held"}, hi, ph);
                chk({tag, " lo held"}, lo, pl);
            end
            step();
        end
        chk({tag, " busy done"}, 32'(busy), 32'd0);
        got = sb.pop_front();
        chk({tag, " hi"}, hi, got.hi);
        chk({tag, " lo"}, lo, got.lo);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = MD_NONE;
        a      = 32'd0;
        b      = 32'd0;
        cancel = 1'b0;
        step();
        step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset stall", 32'(stall_req), 32'd0);
        reset = 1'b0;
        step();

        run_op("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
        run_op("mult2", MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5);
        run_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("div2",  MD_DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
        run_op("divu0", MD_DIVU,  32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 10);
        run_op("divovf", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
        run_op("div0s", MD_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10);
        run_op("divu",  MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 10);

        // Cancelled MULT: stall_req still raised, nothing accepted.
        start  = 1'b1;
        md_op  = MD_MULT;
        a      = 32'd3;
        b      = 32'd3;
        cancel = 1'b1;
        #1;
        chk("cancel stall_req", 32'(stall_req), 32'd1);
        step();
        start  = 1'b0;
        cancel = 1'b0;
        md_op  = MD_NONE;
        chk("cancel busy", 32'(busy), 32'd0);
        step();
        step();
        chk("cancel busy later", 32'(busy), 32'd0);
        chk("cancel hi", hi, 32'd2);
        chk("cancel lo", lo, 32'd14);

        // MTHI takes effect at the next edge, never busy.
        start = 1'b1;
        md_op = MD_MTHI;
        a     = 32'h1234_5678;
        #1;
        chk("mthi stall_req", 32'(stall_req), 32'd0);
        step();
        start = 1'b0;
        md_op = MD_NONE;
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi lo", lo, 32'd14);
        chk("mthi busy", 32'(busy), 32'd0);

        // Cancelled MTLO is blocked; uncancelled MTLO writes.
        start  = 1'b1;
        md_op  = MD_MTLO;
        a      = 32'hDEAD_BEEF;
        cancel = 1'b1;
        step();
        chk("mtlo cancel lo", lo, 32'd14);
        cancel = 1'b0;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        chk("mtlo lo", lo, 32'hDEAD_BEEF);
        chk("mtlo hi", hi, 32'h1234_5678);

        // Op code 7 is a no-op.
        start = 1'b1;
        md_op = 3'd7;
        a     = 32'h5555_5555;
        #1;
        chk("op7 stall_req", 32'(stall_req), 32'd0);
        step();
        start = 1'b0;
        md_op = MD_NONE;
        chk("op7 busy", 32'(busy), 32'd0);
        chk("op7 hi", hi, 32'h1234_5678);
        chk("op7 lo", lo, 32'hDEAD_BEEF);

        // DIV aborted by reset during busy cycle 4.
        start = 1'b1;
        md_op = MD_DIV;
        a     = 32'd50;
        b     = 32'd5;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        for (int i = 1; i < 4; i++) step();
        chk("abort busy@4", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("abort no late commit lo", lo, 32'd0);
        chk("abort no late busy", 32'(busy), 32'd0);

        // Start presented during BUSY is ignored; original result commits.
        start = 1'b1;
        md_op = MD_MULT;
        a     = 32'd3;
        b     = 32'd4;
        step();
        md_op = MD_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        chk("ign stall_req", 32'(stall_req), 32'd1);
        step();
        step();
        step();
        chk("ign busy@5", 32'(busy), 32'd1);
        step();
        chk("ign busy done", 32'(busy), 32'd0);
        chk("ign hi", hi, 32'd0);
        chk("ign lo", lo, 32'd12);
        step();
        step();
        chk("ign no second op", 32'(busy), 32'd0);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
